// File: rtl/block_draw_sequencer.sv
// rtl/block_draw_sequencer.sv - queues 3x3 grid completion events and feeds them one at a time to the rectangle drawer (optional SEQ_DEDUP_EN)
module block_draw_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int RECT_W     = 80,
  parameter int RECT_H     = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid,
  input  logic [3:0] ev_block,
  output logic       ev_ready,
  input  logic       clear,
  output logic       rect_start,
  output logic [9:0] rect_x,
  output logic [8:0] rect_y,
  output logic [9:0] rect_w,
  output logic [8:0] rect_h,
  input  logic       rect_done,
  output logic       busy,
  output logic [8:0] drawn_mask,
  output logic       err_index
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  state_t          state, next_state;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic            accept, idx_ok, push, pop;
  logic            done_hit, mark, cancel;
  logic [3:0]      head, cur_idx;
  logic [8:0]      done_bit;
  logic [9:0]      head_x;
  logic [8:0]      head_y;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign ev_ready = !full;
  assign accept   = ev_valid && ev_ready;
  assign idx_ok   = (ev_block <= 4'd8);
  assign head     = mem[rd_ptr];
  assign done_hit = (state == S_WAIT) && rect_done;
  // A clear seen while this rectangle was in flight (or in the done cycle) suppresses its mask bit
  assign mark     = done_hit && !cancel && !clear;
  assign done_bit = 9'b1 << cur_idx;
  assign busy     = (state != S_IDLE) || !empty;
  assign rect_w   = 10'(RECT_W);
  assign rect_h   = 9'(RECT_H);

`ifdef SEQ_DEDUP_EN
  logic [8:0] pending_mask;
  logic [8:0] ev_bit;
  logic       dup;

  assign ev_bit = idx_ok ? (9'b1 << ev_block) : 9'b0;
  assign dup    = |((pending_mask | drawn_mask) & ev_bit);
  assign push   = accept && idx_ok && !clear && !dup;

  // Track blocks queued or being drawn so repeats are swallowed
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pending_mask <= '0;
    else if (clear) pending_mask <= '0;
    else            pending_mask <= (pending_mask | (push ? ev_bit : 9'b0)) & ~(mark ? done_bit : 9'b0);
  end
`else
  assign push   = accept && idx_ok && !clear;
`endif

  // Grid index to screen origin of its rectangle
  always_comb begin
    head_x = 10'd0;
    head_y = 9'd0;
    case (head)
      4'd0, 4'd3, 4'd6: head_x = 10'd152;
      4'd1, 4'd4, 4'd7: head_x = 10'd282;
      4'd2, 4'd5, 4'd8: head_x = 10'd412;
      default:          head_x = 10'd0;
    endcase
    case (head)
      4'd0, 4'd1, 4'd2: head_y = 9'd226;
      4'd3, 4'd4, 4'd5: head_y = 9'd325;
      4'd6, 4'd7, 4'd8: head_y = 9'd425;
      default:          head_y = 9'd0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // FSM next-state; a clear in LOAD abandons the pop since the queue is being flushed
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (!empty && !clear) next_state = S_LOAD;
      S_LOAD:  next_state = clear ? S_IDLE : S_START;
      S_START: next_state = S_WAIT;
      S_WAIT:  if (rect_done) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rect_start = (state == S_START);
    pop        = (state == S_LOAD) && !clear;
  end

  // Queue storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_block;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Capture the popped block and its coordinates; they stay put until the next pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rect_x  <= '0;
      rect_y  <= '0;
      cur_idx <= '0;
      cancel  <= 1'b0;
    end else begin
      if (pop) begin
        rect_x  <= head_x;
        rect_y  <= head_y;
        cur_idx <= head;
        cancel  <= 1'b0;
      end else if (clear && ((state == S_START) || (state == S_WAIT))) begin
        cancel  <= 1'b1;
      end
    end
  end

  // Completed-block mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      drawn_mask <= '0;
    else if (clear) drawn_mask <= '0;
    else if (mark)  drawn_mask <= drawn_mask | done_bit;
  end

  // Sticky out-of-range index flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  err_index <= 1'b0;
    else if (accept && !idx_ok) err_index <= 1'b1;
  end

endmodule

// File: tb/tb_block_draw_sequencer.sv
// tb/tb_block_draw_sequencer.sv - directed self-checking bench for block_draw_sequencer
module tb_block_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ev_valid;
  logic [3:0] ev_block;
  logic       ev_ready;
  logic       clear;
  logic       rect_start;
  logic [9:0] rect_x;
  logic [8:0] rect_y;
  logic [9:0] rect_w;
  logic [8:0] rect_h;
  logic       rect_done;
  logic       busy;
  logic [8:0] drawn_mask;
  logic       err_index;

  int errors = 0;
  int checks = 0;

  block_draw_sequencer dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_block(ev_block),
    .ev_ready(ev_ready), .clear(clear), .rect_start(rect_start),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_done(rect_done), .busy(busy), .drawn_mask(drawn_mask),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; ev_valid = 1'b0; ev_block = 4'd0; clear = 1'b0; rect_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] blk);
    ev_valid = 1'b1; ev_block = blk;
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  task automatic pulse_done();
    rect_done = 1'b1;
    @(negedge clk);
    rect_done = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (rect_start === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rect_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", rect_start); end
    checks++; if (rect_x !== 10'd0 || rect_y !== 9'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", rect_x, rect_y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (drawn_mask !== 9'h000 || err_index !== 1'b0) begin errors++; $display("FAIL reset_masks: got %0h/%0b expected 0/0", drawn_mask, err_index); end
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", ev_ready); end
    checks++; if (rect_w !== 10'd80 || rect_h !== 9'd50) begin errors++; $display("FAIL rect_wh: got %0d,%0d expected 80,50", rect_w, rect_h); end
  endtask

  task automatic test_single();
    do_reset();
    send(4'd4);
    checks++; if (rect_start !== 1'b0) begin errors++; $display("FAIL single_lat1: got %0b expected 0", rect_start); end
    @(negedge clk);
    checks++; if (rect_start !== 1'b0) begin errors++; $display("FAIL single_lat2: got %0b expected 0", rect_start); end
    @(negedge clk);
    checks++; if (rect_start !== 1'b1) begin errors++; $display("FAIL single_lat3: got %0b expected 1", rect_start); end
    checks++; if (rect_x !== 10'd282 || rect_y !== 9'd325) begin errors++; $display("FAIL single_xy: got %0d,%0d expected 282,325", rect_x, rect_y); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rect_start !== 1'b0 || rect_x !== 10'd282 || rect_y !== 9'd325) begin
        errors++; $display("FAIL single_hold%0d: got start=%0b xy=%0d,%0d expected 0,282,325", i, rect_start, rect_x, rect_y);
      end
    end
    pulse_done();
    checks++; if (drawn_mask !== 9'h010) begin errors++; $display("FAIL single_mask: got %0h expected 010", drawn_mask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] blks [4];
    logic [9:0] ex [4];
    logic [8:0] ey [4];
    int cyc;
    blks = '{4'd0, 4'd8, 4'd2, 4'd6};
    ex   = '{10'd152, 10'd412, 10'd412, 10'd152};
    ey   = '{9'd226, 9'd425, 9'd226, 9'd425};
    do_reset();
    send(4'd4);
    wait_start(6, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL burst_first_start: got timeout expected start"); end
    for (int i = 0; i < 4; i++) begin
      ev_valid = 1'b1; ev_block = blks[i];
      @(negedge clk);
      checks++;
      if (ev_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL burst_ready%0d: got %0b expected %0b", i, ev_ready, (i < 3) ? 1'b1 : 1'b0);
      end
    end
    ev_valid = 1'b0;
    pulse_done();
    for (int i = 0; i < 4; i++) begin
      wait_start(6, cyc);
      checks++;
      if (cyc < 0 || rect_x !== ex[i] || rect_y !== ey[i]) begin
        errors++; $display("FAIL burst_rect%0d: got cyc=%0d xy=%0d,%0d expected %0d,%0d", i, cyc, rect_x, rect_y, ex[i], ey[i]);
      end
      @(negedge clk);
      pulse_done();
    end
    checks++; if (drawn_mask !== 9'h155 || busy !== 1'b0) begin errors++; $display("FAIL burst_mask: got %0h busy=%0b expected 155 busy=0", drawn_mask, busy); end
  endtask

  task automatic test_invalid();
    int cyc;
    do_reset();
    send(4'd11);
    checks++; if (err_index !== 1'b1) begin errors++; $display("FAIL inv_err: got %0b expected 1", err_index); end
    checks++; if (busy !== 1'b0 || ev_ready !== 1'b1) begin errors++; $display("FAIL inv_queue: got busy=%0b ready=%0b expected 0,1", busy, ev_ready); end
    wait_start(6, cyc);
    checks++; if (cyc != -1) begin errors++; $display("FAIL inv_nostart: got start at %0d expected none", cyc); end
    send(4'd1);
    wait_start(6, cyc);
    checks++; if (cyc < 0 || rect_x !== 10'd282 || rect_y !== 9'd226) begin errors++; $display("FAIL inv_follow: got cyc=%0d xy=%0d,%0d expected 282,226", cyc, rect_x, rect_y); end
    @(negedge clk);
    pulse_done();
    checks++; if (drawn_mask !== 9'h002) begin errors++; $display("FAIL inv_mask: got %0h expected 002", drawn_mask); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (err_index !== 1'b1 || drawn_mask !== 9'h000) begin errors++; $display("FAIL inv_sticky: got err=%0b mask=%0h expected 1,000", err_index, drawn_mask); end
  endtask

  task automatic test_clear();
    int cyc;
    int starts;
    do_reset();
    send(4'd3);
    wait_start(6, cyc);
    checks++; if (cyc < 0 || rect_x !== 10'd152 || rect_y !== 9'd325) begin errors++; $display("FAIL clr_start: got cyc=%0d xy=%0d,%0d expected 152,325", cyc, rect_x, rect_y); end
    send(4'd7);
    send(4'd1);
    clear = 1'b1; ev_valid = 1'b1; ev_block = 4'd5;
    @(negedge clk);
    clear = 1'b0; ev_valid = 1'b0;
    checks++; if (busy !== 1'b1 || rect_x !== 10'd152) begin errors++; $display("FAIL clr_inflight: got busy=%0b x=%0d expected 1,152", busy, rect_x); end
    pulse_done();
    checks++; if (busy !== 1'b0 || drawn_mask !== 9'h000) begin errors++; $display("FAIL clr_done: got busy=%0b mask=%0h expected 0,000", busy, drawn_mask); end
    starts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rect_start === 1'b1) starts++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL clr_nostart: got %0d starts expected 0", starts); end
  endtask

  task automatic test_dedup();
    int starts;
    int cd;
    int exp_starts;
`ifdef SEQ_DEDUP_EN
    exp_starts = 1;
`else
    exp_starts = 3;
`endif
    do_reset();
    starts = 0;
    cd = 0;
    for (int i = 0; i < 40; i++) begin
      ev_valid = (i < 3);
      ev_block = 4'd5;
      rect_done = (cd == 1);
      if (cd > 0) cd--;
      @(negedge clk);
      if (rect_start === 1'b1) begin
        starts++;
        cd = 3;
        checks++;
        if (rect_x !== 10'd412 || rect_y !== 9'd325) begin
          errors++; $display("FAIL dedup_xy%0d: got %0d,%0d expected 412,325", starts, rect_x, rect_y);
        end
      end
    end
    ev_valid = 1'b0; rect_done = 1'b0;
    checks++; if (starts != exp_starts) begin errors++; $display("FAIL dedup_count: got %0d expected %0d", starts, exp_starts); end
    checks++; if (drawn_mask !== 9'h020 || busy !== 1'b0) begin errors++; $display("FAIL dedup_mask: got %0h busy=%0b expected 020,0", drawn_mask, busy); end
  endtask

  task automatic test_async_reset();
    int cyc;
    do_reset();
    send(4'd0);
    wait_start(6, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL ares_start: got timeout expected start"); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rect_x !== 10'd0 || rect_y !== 9'd0 || busy !== 1'b0 || rect_start !== 1'b0) begin
      errors++; $display("FAIL ares_immediate: got xy=%0d,%0d busy=%0b start=%0b expected 0,0,0,0", rect_x, rect_y, busy, rect_start);
    end
    @(negedge clk);
    reset = 1'b0;
    pulse_done();
    checks++; if (drawn_mask !== 9'h000 || busy !== 1'b0) begin errors++; $display("FAIL ares_late_done: got mask=%0h busy=%0b expected 000,0", drawn_mask, busy); end
    send(4'd8);
    wait_start(6, cyc);
    checks++; if (cyc < 0 || rect_x !== 10'd412 || rect_y !== 9'd425) begin errors++; $display("FAIL ares_next: got cyc=%0d xy=%0d,%0d expected 412,425", cyc, rect_x, rect_y); end
    @(negedge clk);
    pulse_done();
    checks++; if (drawn_mask !== 9'h100) begin errors++; $display("FAIL ares_mask: got %0h expected 100", drawn_mask); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid();
    test_clear();
    test_dedup();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
